// File: rtl/xcel_mem_arbiter_pkg.sv
// Shared definitions for the accelerator memory-port arbiter: per-side FSM states and
// burst-type encodings.
package xcel_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StData = 2'd2
  } arb_state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

endpackage

// File: rtl/xcel_mem_arbiter_rr_grant.sv
// Combinational round-robin picker: grants the first requester strictly after ptr,
// wrapping cyclically, as a one-hot vector plus its binary index.
module xcel_mem_arbiter_rr_grant #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW:0] sum;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      if (!found && req[sum[PW-1:0]]) begin
        found                 = 1'b1;
        grant[sum[PW-1:0]]    = 1'b1;
        grant_idx             = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/xcel_mem_arbiter.sv
// Shares one memory port between NUM_CH accelerator masters. Read and write sides are
// arbitrated independently, round-robin, with each grant held until the burst's last beat.
module xcel_mem_arbiter
  import xcel_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  // read request / data, slave side
  input  logic [NUM_CH-1:0]                s_rd_req_valid,
  output logic [NUM_CH-1:0]                s_rd_req_ready,
  input  logic [NUM_CH*AXI_AWIDTH-1:0]     s_rd_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]      s_rd_len,
  input  logic [NUM_CH*3-1:0]              s_rd_size,
  input  logic [NUM_CH*2-1:0]              s_rd_burst,
  output logic [AXI_DWIDTH-1:0]            s_rd_data,
  output logic [NUM_CH-1:0]                s_rd_data_valid,
  input  logic [NUM_CH-1:0]                s_rd_data_ready,
  // write request / data, slave side
  input  logic [NUM_CH-1:0]                s_wr_req_valid,
  output logic [NUM_CH-1:0]                s_wr_req_ready,
  input  logic [NUM_CH*AXI_AWIDTH-1:0]     s_wr_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]      s_wr_len,
  input  logic [NUM_CH*3-1:0]              s_wr_size,
  input  logic [NUM_CH*2-1:0]              s_wr_burst,
  input  logic [NUM_CH*AXI_DWIDTH-1:0]     s_wr_data,
  input  logic [NUM_CH-1:0]                s_wr_data_valid,
  output logic [NUM_CH-1:0]                s_wr_data_ready,
  // memory port
  output logic                             m_rd_req_valid,
  input  logic                             m_rd_req_ready,
  output logic [AXI_AWIDTH-1:0]            m_rd_addr,
  output logic [LEN_WIDTH-1:0]             m_rd_len,
  output logic [2:0]                       m_rd_size,
  output logic [1:0]                       m_rd_burst,
  input  logic [AXI_DWIDTH-1:0]            m_rd_data,
  input  logic                             m_rd_data_valid,
  output logic                             m_rd_data_ready,
  output logic                             m_wr_req_valid,
  input  logic                             m_wr_req_ready,
  output logic [AXI_AWIDTH-1:0]            m_wr_addr,
  output logic [LEN_WIDTH-1:0]             m_wr_len,
  output logic [2:0]                       m_wr_size,
  output logic [1:0]                       m_wr_burst,
  output logic [AXI_DWIDTH-1:0]            m_wr_data,
  output logic                             m_wr_data_valid,
  input  logic                             m_wr_data_ready,
  output logic [NUM_CH-1:0]                rd_grant,
  output logic [NUM_CH-1:0]                wr_grant
);

  localparam int unsigned PW = $clog2(NUM_CH);

  logic [AXI_AWIDTH-1:0] rd_addr_a [NUM_CH];
  logic [LEN_WIDTH-1:0]  rd_len_a  [NUM_CH];
  logic [2:0]            rd_size_a [NUM_CH];
  logic [1:0]            rd_burst_a[NUM_CH];
  logic [AXI_AWIDTH-1:0] wr_addr_a [NUM_CH];
  logic [LEN_WIDTH-1:0]  wr_len_a  [NUM_CH];
  logic [2:0]            wr_size_a [NUM_CH];
  logic [1:0]            wr_burst_a[NUM_CH];
  logic [AXI_DWIDTH-1:0] wr_data_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign rd_addr_a[i]  = s_rd_addr[i*AXI_AWIDTH +: AXI_AWIDTH];
    assign rd_len_a[i]   = s_rd_len[i*LEN_WIDTH +: LEN_WIDTH];
    assign rd_size_a[i]  = s_rd_size[i*3 +: 3];
    assign rd_burst_a[i] = s_rd_burst[i*2 +: 2];
    assign wr_addr_a[i]  = s_wr_addr[i*AXI_AWIDTH +: AXI_AWIDTH];
    assign wr_len_a[i]   = s_wr_len[i*LEN_WIDTH +: LEN_WIDTH];
    assign wr_size_a[i]  = s_wr_size[i*3 +: 3];
    assign wr_burst_a[i] = s_wr_burst[i*2 +: 2];
    assign wr_data_a[i]  = s_wr_data[i*AXI_DWIDTH +: AXI_DWIDTH];
  end

  arb_state_e           rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [NUM_CH-1:0]    rd_grant_q, rd_grant_d, wr_grant_q, wr_grant_d;
  logic [PW-1:0]        rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LEN_WIDTH-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [NUM_CH-1:0]    rd_pick, wr_pick;
  logic [PW-1:0]        rd_pick_idx, wr_pick_idx;

  xcel_mem_arbiter_rr_grant #(.N(NUM_CH)) u_rd_rr (
    .req       (s_rd_req_valid),
    .ptr       (rd_ptr_q),
    .grant     (rd_pick),
    .grant_idx (rd_pick_idx)
  );

  xcel_mem_arbiter_rr_grant #(.N(NUM_CH)) u_wr_rr (
    .req       (s_wr_req_valid),
    .ptr       (wr_ptr_q),
    .grant     (wr_pick),
    .grant_idx (wr_pick_idx)
  );

  // Request fields follow the registered owner; valid/ready gating lives in the FSMs.
  assign m_rd_addr  = rd_addr_a[rd_idx_q];
  assign m_rd_len   = rd_len_a[rd_idx_q];
  assign m_rd_size  = rd_size_a[rd_idx_q];
  assign m_rd_burst = rd_burst_a[rd_idx_q];
  assign m_wr_addr  = wr_addr_a[wr_idx_q];
  assign m_wr_len   = wr_len_a[wr_idx_q];
  assign m_wr_size  = wr_size_a[wr_idx_q];
  assign m_wr_burst = wr_burst_a[wr_idx_q];
  assign m_wr_data  = wr_data_a[wr_idx_q];
  assign s_rd_data  = m_rd_data;
  assign rd_grant   = rd_grant_q;
  assign wr_grant   = wr_grant_q;

  always_comb begin
    rd_state_d      = rd_state_q;
    rd_grant_d      = rd_grant_q;
    rd_idx_d        = rd_idx_q;
    rd_ptr_d        = rd_ptr_q;
    rd_cnt_d        = rd_cnt_q;
    m_rd_req_valid  = 1'b0;
    m_rd_data_ready = 1'b0;
    s_rd_req_ready  = '0;
    s_rd_data_valid = '0;
    case (rd_state_q)
      StIdle: begin
        if (|s_rd_req_valid) begin
          rd_grant_d = rd_pick;
          rd_idx_d   = rd_pick_idx;
          rd_state_d = StReq;
        end
      end
      StReq: begin
        m_rd_req_valid           = s_rd_req_valid[rd_idx_q];
        s_rd_req_ready[rd_idx_q] = m_rd_req_ready;
        if (s_rd_req_valid[rd_idx_q] && m_rd_req_ready) begin
          rd_cnt_d   = rd_len_a[rd_idx_q];
          rd_state_d = StData;
        end
      end
      StData: begin
        m_rd_data_ready           = s_rd_data_ready[rd_idx_q];
        s_rd_data_valid[rd_idx_q] = m_rd_data_valid;
        if (m_rd_data_valid && s_rd_data_ready[rd_idx_q]) begin
          if (rd_cnt_q == '0) begin
            rd_ptr_d   = rd_idx_q;
            rd_grant_d = '0;
            rd_state_d = StIdle;
          end else begin
            rd_cnt_d = rd_cnt_q - 1'b1;
          end
        end
      end
      default: rd_state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_state_d      = wr_state_q;
    wr_grant_d      = wr_grant_q;
    wr_idx_d        = wr_idx_q;
    wr_ptr_d        = wr_ptr_q;
    wr_cnt_d        = wr_cnt_q;
    m_wr_req_valid  = 1'b0;
    m_wr_data_valid = 1'b0;
    s_wr_req_ready  = '0;
    s_wr_data_ready = '0;
    case (wr_state_q)
      StIdle: begin
        if (|s_wr_req_valid) begin
          wr_grant_d = wr_pick;
          wr_idx_d   = wr_pick_idx;
          wr_state_d = StReq;
        end
      end
      StReq: begin
        m_wr_req_valid           = s_wr_req_valid[wr_idx_q];
        s_wr_req_ready[wr_idx_q] = m_wr_req_ready;
        if (s_wr_req_valid[wr_idx_q] && m_wr_req_ready) begin
          wr_cnt_d   = wr_len_a[wr_idx_q];
          wr_state_d = StData;
        end
      end
      StData: begin
        m_wr_data_valid           = s_wr_data_valid[wr_idx_q];
        s_wr_data_ready[wr_idx_q] = m_wr_data_ready;
        if (s_wr_data_valid[wr_idx_q] && m_wr_data_ready) begin
          if (wr_cnt_q == '0) begin
            wr_ptr_d   = wr_idx_q;
            wr_grant_d = '0;
            wr_state_d = StIdle;
          end else begin
            wr_cnt_d = wr_cnt_q - 1'b1;
          end
        end
      end
      default: wr_state_d = StIdle;
    endcase
  end

  // Pointer starts at the last channel so ch0 is the first winner after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= StIdle;
      rd_grant_q <= '0;
      rd_idx_q   <= '0;
      rd_ptr_q   <= PW'(NUM_CH - 1);
      rd_cnt_q   <= '0;
      wr_state_q <= StIdle;
      wr_grant_q <= '0;
      wr_idx_q   <= '0;
      wr_ptr_q   <= PW'(NUM_CH - 1);
      wr_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_idx_q   <= rd_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_idx_q   <= wr_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

endmodule
